pipe_mux: RTL and testbench
===========================

PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 Parameter NUM_IN, default 4: number of data inputs; legal range 2..16.
REQ-002 Parameter DATA_W, default 32: width of each data input and of the output.
REQ-003 Derived width SEL_W = ceil(log2(NUM_IN)), minimum 1, applies to sel.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port in_data, input, NUM_IN*DATA_W: packed inputs; slot k occupies bits [k*DATA_W +: DATA_W].
REQ-008 Port in_valid, input, 1: the selected slot carries a live instruction/operand this cycle.
REQ-009 Port sel, input, SEL_W: index of the slot to capture.
REQ-010 Port stall, input, 1: hold the output stage.
REQ-011 Port flush, input, 1: squash the output stage to a bubble.
REQ-012 Port out_data, output, DATA_W: registered selected data.
REQ-013 Port out_valid, output, 1: registered validity of out_data.
REQ-014 Port sel_err, output, 1: registered flag; the captured sel was out of range.
REQ-015 Port stall_cnt, output, 8: consecutive stall cycles, saturating.

Function
REQ-016 The block SHALL have one register stage; the capture latency from in_* to out_* SHALL be exactly 1 clock.
REQ-017 Update priority each rising edge SHALL be rst > flush > stall > capture.
REQ-018 Capture (no rst, flush or stall): out_data <= slot[sel] when sel < NUM_IN, else all zeros.
REQ-019 Capture: out_valid <= in_valid; sel_err <= in_valid AND (sel >= NUM_IN).
REQ-020 When sel >= NUM_IN and in_valid = 0, out_data SHALL be zero and sel_err SHALL be 0.
REQ-021 Stall (no rst, no flush): out_data, out_valid and sel_err SHALL hold their values; inputs are ignored.
REQ-022 Flush (no rst): out_data <= 0, out_valid <= 0, sel_err <= 0, regardless of stall.
REQ-023 stall_cnt SHALL increment by 1 on each edge where stall = 1, flush = 0 and rst = 0.
REQ-024 stall_cnt SHALL saturate at 255 and never wrap to 0.
REQ-025 stall_cnt SHALL clear to 0 on any edge where stall = 0 or flush = 1.
REQ-026 flush and stall asserted together SHALL act as flush and SHALL clear stall_cnt.
REQ-027 Outputs SHALL be driven only from registers, with no combinational path from any input to any output.
REQ-028 For NUM_IN a power of two, sel_err SHALL remain 0 in all cycles.

Reset
REQ-029 On an edge with rst = 1: out_data = 0, out_valid = 0, sel_err = 0, stall_cnt = 0.
REQ-030 rst asserted during stall or flush SHALL override both; the first capture after rst deasserts SHALL follow REQ-018/019.
REQ-031 Before the first rst edge, output values are unspecified; the bench SHALL NOT check them.

Verification
REQ-032 NUM_IN=4, DATA_W=32, slots {0x11,0x22,0x33,0x44}, sel=2, in_valid=1 -> next edge out_data=0x33, out_valid=1, sel_err=0.
REQ-033 Capture 0x33, then hold stall=1 for 3 edges while sel=0 -> out_data stays 0x33, stall_cnt=1,2,3; stall=0 -> out_data=0x11, stall_cnt=0.
REQ-034 NUM_IN=5, sel=6, in_valid=1 -> out_data=0, out_valid=1, sel_err=1; same with in_valid=0 -> sel_err=0.
REQ-035 stall=1 and flush=1 together while out_valid=1 -> out_valid=0, out_data=0, stall_cnt=0.
REQ-036 stall held 300 edges -> stall_cnt reaches 255 at edge 255 and holds 255 through edge 300.
REQ-037 rst=1 on an edge during stall with stall_cnt=10 and out_valid=1 -> all outputs 0; next capture with sel=1, in_valid=1 -> out_data=0x22.

Source files
------------

// File: rtl/pipe_mux.sv
// pipe_mux: single-register-stage N:1 data selector with pipeline
// controls (flush squashes, stall holds) and a saturating counter of
// consecutive stall cycles. All outputs come straight from flops.

module pipe_mux #(
    parameter  int NUM_IN = 4,
    parameter  int DATA_W = 32,
    localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic                     in_valid,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     stall,
    input  logic                     flush,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     sel_err,
    output logic [7:0]               stall_cnt
);

    // One wider than sel so the comparison also works when NUM_IN is a
    // power of two (every sel code is then in range).
    localparam logic [SEL_W:0] NUM_IN_V  = (SEL_W + 1)'(NUM_IN);
    localparam logic [7:0]     CNT_MAX   = 8'hFF;

    logic [DATA_W-1:0] slots [NUM_IN];
    logic [DATA_W-1:0] sel_data;
    logic              sel_ok;
    logic [DATA_W-1:0] cap_data;
    logic              cap_valid;
    logic              cap_err;

    // Split the packed input bus into one word per slot.
    genvar k;
    generate
        for (k = 0; k < NUM_IN; k++) begin : g_slot
            assign slots[k] = in_data[k*DATA_W +: DATA_W];
        end
    endgenerate

    // Select the addressed slot; codes past the last slot select nothing.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_data = slots[i];
            end
        end
    end

    // Value the output stage takes on a plain capture edge. Out-of-range
    // selects always yield zero data; the error flag is only raised for a
    // live transfer so idle garbage on sel never reports an error.
    always_comb begin
        sel_ok    = ({1'b0, sel} < NUM_IN_V);
        cap_data  = sel_ok ? sel_data : '0;
        cap_valid = in_valid;
        cap_err   = in_valid & ~sel_ok;
    end

    // Output stage: reset, then flush, then stall (hold), then capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else if (flush) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else if (!stall) begin
            out_data  <= cap_data;
            out_valid <= cap_valid;
            sel_err   <= cap_err;
        end
    end

    // Count back-to-back stall edges; any non-stall edge or a flush
    // restarts the run, and the count sticks at its maximum.
    always_ff @(posedge clk) begin
        if (rst || flush || !stall) begin
            stall_cnt <= 8'd0;
        end else if (stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pipe_mux.sv
// tb_pipe_mux: drives a 4-input and a 5-input pipe_mux with shared
// stimulus; a reference model predicts each edge's outputs into
// per-instance queues that a monitor drains and compares.

module tb_pipe_mux;

    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [2:0]   sel;
    logic         stall;
    logic         flush;
    logic [31:0]  slots [5];
    logic [31:0]  stage [5];
    logic [127:0] in_data4;
    logic [159:0] in_data5;

    logic [31:0]  out_data4, out_data5;
    logic         out_valid4, out_valid5;
    logic         sel_err4, sel_err5;
    logic [7:0]   stall_cnt4, stall_cnt5;

    exp_t q4 [$];
    exp_t q5 [$];
    exp_t m4, m5;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign in_data4 = {slots[3], slots[2], slots[1], slots[0]};
    assign in_data5 = {slots[4], slots[3], slots[2], slots[1], slots[0]};

    pipe_mux #(.NUM_IN(4), .DATA_W(32)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data4),
        .in_valid  (in_valid),
        .sel       (sel[1:0]),
        .stall     (stall),
        .flush     (flush),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .sel_err   (sel_err4),
        .stall_cnt (stall_cnt4)
    );

    pipe_mux #(.NUM_IN(5), .DATA_W(32)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data5),
        .in_valid  (in_valid),
        .sel       (sel),
        .stall     (stall),
        .flush     (flush),
        .out_data  (out_data5),
        .out_valid (out_valid5),
        .sel_err   (sel_err5),
        .stall_cnt (stall_cnt5)
    );

    // Reference behaviour of one edge, straight from the priority rules.
    function automatic exp_t modelNext(exp_t cur, int n, int s,
                                       bit r, bit v, bit st, bit fl);
        exp_t nx;
        nx = cur;
        if (r || fl) begin
            nx.data  = 0;
            nx.valid = 0;
            nx.err   = 0;
            nx.cnt   = 0;
        end else if (st) begin
            nx.cnt = (cur.cnt == 8'd255) ? 8'd255 : cur.cnt + 8'd1;
        end else begin
            nx.cnt   = 0;
            nx.data  = (s < n) ? slots[s] : 32'd0;
            nx.valid = v;
            nx.err   = v && (s >= n);
        end
        return nx;
    endfunction

    // Drive one cycle of inputs away from the clock edge and queue the
    // outputs each instance should show after the coming rising edge.
    task automatic applyStimulus(input bit r, input bit v, input int s,
                                 input bit st, input bit fl);
        @(negedge clk);
        #1;
        rst      = r;
        in_valid = v;
        sel      = 3'(s);
        stall    = st;
        flush    = fl;
        for (int i = 0; i < 5; i++) slots[i] = stage[i];
        m4 = modelNext(m4, 4, s % 4, r, v, st, fl);
        m5 = modelNext(m5, 5, s,     r, v, st, fl);
        q4.push_back(m4);
        q5.push_back(m5);
    endtask

    task automatic checkOutput(input string name, input exp_t e,
                               input logic [31:0] d, input logic vl,
                               input logic er, input logic [7:0] c);
        tests += 4;
        if (d !== e.data) begin
            fails++;
            $display("[TB] FAIL %s out_data: got %h expected %h at %0t", name, d, e.data, $time);
        end
        if (vl !== e.valid) begin
            fails++;
            $display("[TB] FAIL %s out_valid: got %b expected %b at %0t", name, vl, e.valid, $time);
        end
        if (er !== e.err) begin
            fails++;
            $display("[TB] FAIL %s sel_err: got %b expected %b at %0t", name, er, e.err, $time);
        end
        if (c !== e.cnt) begin
            fails++;
            $display("[TB] FAIL %s stall_cnt: got %0d expected %0d at %0t", name, c, e.cnt, $time);
        end
    endtask

    // Monitor: each falling edge, compare the previous rising edge result.
    always @(negedge clk) begin
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            checkOutput("n4", e, out_data4, out_valid4, sel_err4, stall_cnt4);
        end
        if (q5.size() > 0) begin
            e = q5.pop_front();
            checkOutput("n5", e, out_data5, out_valid5, sel_err5, stall_cnt5);
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        sel      = 3'd0;
        stall    = 1'b0;
        flush    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stage[i] = 32'd0;
            slots[i] = 32'd0;
        end
        m4 = '{data: 0, valid: 0, err: 0, cnt: 0};
        m5 = m4;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 2, 1, 1);

        stage[0] = 32'h11; stage[1] = 32'h22; stage[2] = 32'h33;
        stage[3] = 32'h44; stage[4] = 32'h55;

        // Basic capture of slot 2.
        applyStimulus(0, 1, 2, 0, 0);
        // Hold through three stalls, then capture slot 0.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        // Out-of-range select on the 5-input instance, live and idle.
        applyStimulus(0, 1, 6, 0, 0);
        applyStimulus(0, 0, 6, 0, 0);
        applyStimulus(0, 1, 7, 0, 0);
        // Flush together with stall while holding valid data.
        applyStimulus(0, 1, 3, 0, 0);
        applyStimulus(0, 1, 3, 1, 0);
        applyStimulus(0, 1, 1, 1, 1);
        // Long stall to exercise saturation.
        applyStimulus(0, 1, 4, 0, 0);
        for (int i = 0; i < 300; i++) applyStimulus(0, 1, 2, 1, 0);
        applyStimulus(0, 1, 4, 0, 0);
        // Reset in the middle of a stall, then capture slot 1.
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(0, 1, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < 5; j++) stage[j] = $urandom;
            applyStimulus($urandom_range(0, 39) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 7),
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (q4.size() != 0 || q5.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: pending %0d/%0d expected 0/0", q4.size(), q5.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
